// File: rtl/ahb_bridge_pkg.sv
// Shared types for the AHB-to-APB bridge: FSM states, AHB transfer/response codes and
// helpers that classify a transfer and derive its APB byte strobes.
package ahb_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StAccess,
        StErr1,
        StErr2
    } bridge_state_e;

    typedef enum logic [1:0] {
        TransIdle   = 2'b00,
        TransBusy   = 2'b01,
        TransNonseq = 2'b10,
        TransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RespOkay  = 2'b00,
        RespError = 2'b01
    } hresp_e;

    // Only byte, half-word and naturally aligned word transfers reach the APB side.
    function automatic logic xfer_legal(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            3'd0:    ok = 1'b1;
            3'd1:    ok = ~addr_lo[0];
            3'd2:    ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] strb_calc(input logic write, input logic [2:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = 4'h0;
        if (write) begin
            case (size)
                3'd0:    strb = 4'b0001 << addr_lo;
                3'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                default: strb = 4'b1111;
            endcase
        end
        return strb;
    endfunction

endpackage

// File: rtl/ahb2apb_wdog.sv
// ACCESS-phase watchdog: flags the cycle in which the stall count reaches TIMEOUT_CYCLES.
// Only instantiated when KVIPS_AHB2APB_TIMEOUT_EN is defined.
module ahb2apb_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic count,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Any cycle without a stall restarts the count, so only consecutive stalls add up.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + 1'b1;
        end else begin
            cnt_q <= '0;
        end
    end

    assign expired = count && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge with two-cycle AHB error responses.
// Define KVIPS_AHB2APB_TIMEOUT_EN to compile in the ACCESS-phase watchdog.
module ahb2apb_bridge
    import ahb_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned PADDR_W        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic [ADDR_W-1:0]   HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [DATA_W-1:0]   HWDATA,
    input  logic                HREADY,
    output logic                HREADYOUT,
    output logic [1:0]          HRESP,
    output logic [DATA_W-1:0]   HRDATA,
    output logic                PSEL,
    output logic                PENABLE,
    output logic [PADDR_W-1:0]  PADDR,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    bridge_state_e state_q, state_d;

    logic [PADDR_W-1:0]  paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [DATA_W/8-1:0] pstrb_q;

    logic   xfer_req;
    logic   legal;
    logic   load;
    logic   hready_out;
    hresp_e resp;
    logic   psel;
    logic   penable;
    logic   timeout;
    logic   unused_haddr;

    assign unused_haddr = ^HADDR[ADDR_W-1:PADDR_W];

    assign xfer_req = HSEL && HREADY && ((HTRANS == TransNonseq) || (HTRANS == TransSeq));
    assign legal    = xfer_legal(HSIZE, HADDR[1:0]);
    // The address phase only counts while this slave is itself ready.
    assign load     = hready_out && xfer_req && legal;

`ifdef KVIPS_AHB2APB_TIMEOUT_EN
    logic wdog_count;

    assign wdog_count = (state_q == StAccess) && !PREADY;

    ahb2apb_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .count   (wdog_count),
        .expired (timeout)
    );
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hready_out = 1'b1;
        resp       = RespOkay;
        psel       = 1'b0;
        penable    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (xfer_req) begin
                    state_d = legal ? StSetup : StErr1;
                end
            end
            StSetup: begin
                hready_out = 1'b0;
                psel       = 1'b1;
                state_d    = StAccess;
            end
            StAccess: begin
                hready_out = 1'b0;
                psel       = 1'b1;
                penable    = 1'b1;
                if (PREADY && !PSLVERR) begin
                    hready_out = 1'b1;
                    if (xfer_req) begin
                        state_d = legal ? StSetup : StErr1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (PREADY || timeout) begin
                    state_d = StErr1;
                end
            end
            StErr1: begin
                hready_out = 1'b0;
                resp       = RespError;
                state_d    = StErr2;
            end
            StErr2: begin
                resp = RespError;
                if (xfer_req) begin
                    state_d = legal ? StSetup : StErr1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= StIdle;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                paddr_q  <= HADDR[PADDR_W-1:0];
                pwrite_q <= HWRITE;
                pstrb_q  <= strb_calc(HWRITE, HSIZE, HADDR[1:0]);
            end
            if (state_q == StSetup) begin
                pwdata_q <= HWDATA;
            end
        end
    end

    assign HREADYOUT = hready_out;
    assign HRESP     = resp;
    assign HRDATA    = (state_q == StAccess && PREADY && !PSLVERR && !pwrite_q) ? PRDATA : '0;
    assign PSEL      = psel;
    assign PENABLE   = penable;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    // Write data arrives in the AHB data phase, which coincides with SETUP.
    assign PWDATA    = (state_q == StSetup) ? HWDATA : pwdata_q;
    assign PSTRB     = pstrb_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge; AHB responses are checked against a scoreboard queue.
module tb_ahb2apb_bridge;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] ERROR  = 2'b01;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = T_IDLE;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = '0;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [15:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b1;
    logic        PSLVERR = 1'b0;

    ahb2apb_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .PADDR_W        (16),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          chk_data;
        int          start;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive an address phase; the caller supplies the clock edge that samples it.
    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] sz,
                              input bit push, input string tag, input logic [1:0] resp,
                              input logic [31:0] rd, input bit chkd, input int lat);
        exp_t e;
        HSEL   = 1'b1;
        HTRANS = T_NSEQ;
        HADDR  = a;
        HWRITE = w;
        HSIZE  = sz;
        if (push) begin
            e.tag = tag; e.resp = resp; e.rdata = rd; e.chk_data = chkd;
            e.start = cyc; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic idle_bus();
        HSEL   = 1'b0;
        HTRANS = T_IDLE;
    endtask

    // Wait (bounded) for HREADYOUT=1, then pop and compare the expected response.
    task automatic wait_done(input int max_cyc);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int n = 0; n < max_cyc && !got; n++) begin
            @(negedge HCLK);
            if (HREADYOUT === 1'b1) got = 1'b1;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, "_ready"}, 32'(got), 32'd1);
            check({e.tag, "_resp"}, 32'(HRESP), 32'(e.resp));
            check({e.tag, "_lat"}, 32'(cyc - e.start), 32'(e.lat));
            if (e.chk_data) check({e.tag, "_hrdata"}, HRDATA, e.rdata);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hreadyout"}, 32'(HREADYOUT), 32'd1);
        check({tag, "_hresp"}, 32'(HRESP), 32'(OKAY));
        check({tag, "_hrdata"}, HRDATA, 32'd0);
        check({tag, "_psel"}, 32'(PSEL), 32'd0);
        check({tag, "_penable"}, 32'(PENABLE), 32'd0);
        check({tag, "_paddr"}, 32'(PADDR), 32'd0);
        check({tag, "_pwdata"}, PWDATA, 32'd0);
        check({tag, "_pstrb"}, 32'(PSTRB), 32'd0);
        check({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
    endtask

    initial begin
        // Reset state
        @(negedge HCLK);
        check_reset_outputs("rst");
        tick();
        HRESETn = 1'b1;

        // BUSY with HSEL is a no-op
        HSEL = 1'b1; HTRANS = T_BUSY; HADDR = 32'h100;
        tick();
        idle_bus();
        @(negedge HCLK);
        check("busy_psel", 32'(PSEL), 32'd0);
        check("busy_hreadyout", 32'(HREADYOUT), 32'd1);
        check("busy_hresp", 32'(HRESP), 32'(OKAY));

        // Word write, zero wait states
        PREADY = 1'b1;
        drive_addr(32'h0000_1004, 1'b1, 3'd2, 1'b1, "wr", OKAY, 32'h0, 1'b0, 2);
        tick();
        idle_bus();
        HWDATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        check("wr_setup_psel", 32'(PSEL), 32'd1);
        check("wr_setup_penable", 32'(PENABLE), 32'd0);
        check("wr_setup_hreadyout", 32'(HREADYOUT), 32'd0);
        check("wr_paddr", 32'(PADDR), 32'h1004);
        check("wr_pwrite", 32'(PWRITE), 32'd1);
        check("wr_pwdata", PWDATA, 32'hDEAD_BEEF);
        check("wr_pstrb", 32'(PSTRB), 32'hF);
        tick();
        HWDATA = 32'h0BAD_0BAD;
        wait_done(4);
        check("wr_access_penable", 32'(PENABLE), 32'd1);
        check("wr_access_pwdata", PWDATA, 32'hDEAD_BEEF);
        tick();
        @(negedge HCLK);
        check("wr_idle_psel", 32'(PSEL), 32'd0);

        // Word read, two wait states
        PREADY = 1'b0;
        drive_addr(32'h0000_2008, 1'b0, 3'd2, 1'b1, "rd_ws", OKAY, 32'h1234_5678, 1'b1, 4);
        tick();
        idle_bus();
        @(negedge HCLK);
        check("rd_paddr", 32'(PADDR), 32'h2008);
        check("rd_pstrb", 32'(PSTRB), 32'h0);
        check("rd_pwrite", 32'(PWRITE), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge HCLK);
            check("rd_wait_penable", 32'(PENABLE), 32'd1);
            check("rd_wait_hreadyout", 32'(HREADYOUT), 32'd0);
        end
        tick();
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        wait_done(4);
        tick();
        PRDATA = 32'h0;

        // Byte write completing into a back-to-back half-word write
        drive_addr(32'h5A5A_0013, 1'b1, 3'd0, 1'b1, "wr_b", OKAY, 32'h0, 1'b0, 2);
        tick();
        idle_bus();
        HWDATA = 32'h1122_3344;
        @(negedge HCLK);
        check("wr_b_paddr", 32'(PADDR), 32'h0013);
        check("wr_b_pstrb", 32'(PSTRB), 32'h8);
        tick();
        drive_addr(32'h0000_0106, 1'b1, 3'd1, 1'b1, "wr_h", OKAY, 32'h0, 1'b0, 2);
        wait_done(2);
        tick();
        idle_bus();
        HWDATA = 32'h5566_7788;
        @(negedge HCLK);
        check("wr_h_setup_psel", 32'(PSEL), 32'd1);
        check("wr_h_setup_penable", 32'(PENABLE), 32'd0);
        check("wr_h_paddr", 32'(PADDR), 32'h0106);
        check("wr_h_pstrb", 32'(PSTRB), 32'hC);
        check("wr_h_pwdata", PWDATA, 32'h5566_7788);
        wait_done(4);
        tick();

        // Misaligned word: no APB access, two-cycle error
        drive_addr(32'h0000_1002, 1'b1, 3'd2, 1'b1, "mis", ERROR, 32'h0, 1'b0, 2);
        tick();
        idle_bus();
        @(negedge HCLK);
        check("mis_err1_psel", 32'(PSEL), 32'd0);
        check("mis_err1_hreadyout", 32'(HREADYOUT), 32'd0);
        check("mis_err1_hresp", 32'(HRESP), 32'(ERROR));
        wait_done(4);
        check("mis_err2_psel", 32'(PSEL), 32'd0);
        tick();
        @(negedge HCLK);
        check("mis_idle_hresp", 32'(HRESP), 32'(OKAY));

        // Slave error, then a fresh read
        PSLVERR = 1'b1;
        drive_addr(32'h0000_2000, 1'b1, 3'd2, 1'b1, "slverr", ERROR, 32'h0, 1'b0, 4);
        tick();
        idle_bus();
        HWDATA = 32'hCAFE_0001;
        tick();
        @(negedge HCLK);
        check("slverr_access_hreadyout", 32'(HREADYOUT), 32'd0);
        check("slverr_access_penable", 32'(PENABLE), 32'd1);
        tick();
        PSLVERR = 1'b0;
        @(negedge HCLK);
        check("slverr_err1_psel", 32'(PSEL), 32'd0);
        check("slverr_err1_hreadyout", 32'(HREADYOUT), 32'd0);
        check("slverr_err1_hresp", 32'(HRESP), 32'(ERROR));
        wait_done(3);
        tick();
        drive_addr(32'h0000_3008, 1'b0, 3'd2, 1'b1, "rd_after", OKAY, 32'hA5A5_0F0F, 1'b1, 2);
        tick();
        idle_bus();
        PRDATA = 32'hA5A5_0F0F;
        @(negedge HCLK);
        check("rd_after_psel", 32'(PSEL), 32'd1);
        check("rd_after_paddr", 32'(PADDR), 32'h3008);
        wait_done(4);
        tick();
        PRDATA = 32'h0;

`ifdef KVIPS_AHB2APB_TIMEOUT_EN
        // Stuck slave: watchdog ends ACCESS after four cycles
        PREADY = 1'b0;
        drive_addr(32'h0000_4000, 1'b0, 3'd2, 1'b1, "tmo", ERROR, 32'h0, 1'b0, 7);
        tick();
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge HCLK);
            check("tmo_access_psel", 32'(PSEL), 32'd1);
            check("tmo_access_penable", 32'(PENABLE), 32'd1);
        end
        tick();
        @(negedge HCLK);
        check("tmo_err1_psel", 32'(PSEL), 32'd0);
        check("tmo_err1_penable", 32'(PENABLE), 32'd0);
        check("tmo_err1_hreadyout", 32'(HREADYOUT), 32'd0);
        check("tmo_err1_hresp", 32'(HRESP), 32'(ERROR));
        wait_done(3);
        PREADY = 1'b1;
        tick();
`else
        // Without the watchdog a stalled ACCESS just waits
        PREADY = 1'b0;
        drive_addr(32'h0000_4000, 1'b0, 3'd2, 1'b1, "nowdog", OKAY, 32'hCAFE_F00D, 1'b1, 10);
        tick();
        idle_bus();
        for (int i = 0; i < 8; i++) begin
            tick();
            @(negedge HCLK);
            check("nowdog_psel", 32'(PSEL), 32'd1);
            check("nowdog_hreadyout", 32'(HREADYOUT), 32'd0);
        end
        tick();
        PREADY = 1'b1;
        PRDATA = 32'hCAFE_F00D;
        wait_done(3);
        tick();
        PRDATA = 32'h0;
`endif

        // Reset asserted mid-ACCESS
        PREADY = 1'b0;
        drive_addr(32'h0000_5000, 1'b1, 3'd2, 1'b0, "", OKAY, 32'h0, 1'b0, 0);
        tick();
        idle_bus();
        HWDATA = 32'hFFFF_0000;
        tick();
        @(negedge HCLK);
        check("rstmid_in_access", 32'(PENABLE), 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("rstmid");
        check("rstmid_fsm", 32'(dut.state_q), 32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        PREADY = 1'b1;
        @(negedge HCLK);
        check("rstrel_psel", 32'(PSEL), 32'd0);
        check("rstrel_hreadyout", 32'(HREADYOUT), 32'd1);
        tick();
        @(negedge HCLK);
        check("rstrel_no_start", 32'(PSEL), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
